odetojoy: RTL and testbench

//  Single-octave FPGA piano with an "Ode to Joy" practice tracker. Each of 8 switches is one
//  key: sw[7]=C4, sw[6]=D4, sw[5]=E4, sw[4]=F4, sw[3]=G4, sw[2]=A4, sw[1]=B4, sw[0]=C5.
//  The held key drives a square wave on FREQ (to the speaker pin). Led shows which key the

---
 rtl/odetojoy_pkg.sv | 46 ++++
 rtl/tone_gen.sv | 54 +++++
 rtl/odetojoy.sv | 88 ++++++++
 tb/tb_odetojoy.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/odetojoy_pkg.sv
// Shared constants for the single-octave piano: note table, tone divider math
// and the "Ode to Joy" melody used by the practice tracker.
package odetojoy_pkg;

  localparam int          NUM_KEYS = 8;
  localparam int          HALF_W   = 18;
  localparam int          SEQ_LEN  = 15;
  localparam logic [3:0]  LAST_IDX = 4'(SEQ_LEN);

  typedef logic [2:0] key_t;

  // Note frequencies in centi-Hz, indexed by switch number (sw[0]=C5 .. sw[7]=C4).
  localparam int unsigned NOTE_CHZ [NUM_KEYS] = '{
    52325, 49388, 44000, 39200, 34923, 32963, 29366, 26163
  };

  // E E F G G F E D C C D E E D D, as switch indices.
  localparam key_t MELODY [SEQ_LEN] = '{
    3'd5, 3'd5, 3'd4, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd5, 3'd6, 3'd6
  };

  // round(clk_hz / (2*f)); only ever called with constant arguments.
  function automatic logic [HALF_W-1:0] half_cycles(input longint unsigned clk_hz,
                                                    input key_t key);
    longint unsigned den;
    longint unsigned num;
    den = 64'(NOTE_CHZ[key]) * 64'd2;
    num = clk_hz * 64'd100 + 64'(NOTE_CHZ[key]);
    return HALF_W'(num / den);
  endfunction

  // Mux lookup so the done index (15) never reads past the table.
  function automatic key_t melody_at(input logic [3:0] i);
    key_t k;
    k = '0;
    for (int j = 0; j < SEQ_LEN; j++)
      if (i == 4'(j)) k = MELODY[j];
    return k;
  endfunction

  function automatic logic [7:0] led_for(input logic [3:0] i);
    return (i >= LAST_IDX) ? 8'hFF : (8'd1 << melody_at(i));
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave divider: FREQ toggles every half_period cycles while a note is held,
// and drops to 0 when no note is selected.
module tone_gen
  import odetojoy_pkg::*;
#(
  parameter int W = HALF_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         note_valid,
  input  logic [W-1:0] half_period,
  output logic         FREQ
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] half_q;
  logic         vld_q;
  logic         freq_q, freq_d;

  // A note change is seen as a new half period while a note was already playing;
  // two notes with identical half periods produce identical tones, so no restart is needed.
  always_comb begin
    cnt_d  = '0;
    freq_d = 1'b0;
    if (note_valid) begin
      freq_d = freq_q;
      if (vld_q && (half_period != half_q)) begin
        cnt_d = '0;
      end else if (cnt_q >= half_period - W'(1)) begin
        cnt_d  = '0;
        freq_d = ~freq_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q  <= '0;
      half_q <= '0;
      vld_q  <= 1'b0;
      freq_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_period;
      vld_q  <= note_valid;
      freq_q <= freq_d;
    end
  end

  assign FREQ = freq_q;

endmodule

// File: rtl/odetojoy.sv
// Piano top: key synchronizer, lowest-index priority select, press detection
// and the melody tracker that drives the next-note hint on Led.
module odetojoy
  import odetojoy_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] sw,
  output logic       FREQ,
  output logic [7:0] Led
);

  logic [7:0]        s1_d, s1_q, ss_q;
  logic [1:0]        vld_pipe_q;
  logic              held_q, held_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        led_q, led_d;
  key_t              win;
  logic              note_vld, press;
  logic [HALF_W-1:0] half_tbl [NUM_KEYS];
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    s1_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) s1_d[i] = (sw[i] === 1'b1);
  end

  always_comb begin
    win = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (ss_q[i]) win = key_t'(i);
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_half
    assign half_tbl[g] = half_cycles(64'(CLK_HZ), key_t'(g));
  end

  assign note_vld = |ss_q;
  assign half_sel = half_tbl[win];

  // held_q comes out of reset set and only follows ss once the synchronizer has
  // refilled, so a key held through reset must be released before it counts.
  always_comb begin
    held_d = vld_pipe_q[1] ? note_vld : held_q;
    press  = vld_pipe_q[1] & ~held_q & note_vld;
  end

  always_comb begin
    idx_d = idx_q;
    if (press) begin
      if ((idx_q != LAST_IDX) && (win == melody_at(idx_q))) idx_d = idx_q + 4'd1;
      else if (win == MELODY[0])                            idx_d = 4'd1;
      else                                                  idx_d = 4'd0;
    end
    led_d = led_for(idx_d);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s1_q       <= '0;
      ss_q       <= '0;
      vld_pipe_q <= '0;
      held_q     <= 1'b1;
      idx_q      <= '0;
      led_q      <= led_for(4'd0);
    end else begin
      s1_q       <= s1_d;
      ss_q       <= s1_q;
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
      held_q     <= held_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
    end
  end

  assign Led = led_q;

  tone_gen #(.W(HALF_W)) u_tone (
    .CLK         (CLK),
    .RESET       (RESET),
    .note_valid  (note_vld),
    .half_period (half_sel),
    .FREQ        (FREQ)
  );

endmodule

// File: tb/tb_odetojoy.sv
// Scoreboard bench for odetojoy at CLK_HZ=10_000: stimulus queues timestamped
// expectations, a negedge monitor pops and compares them against FREQ/Led.
module tb_odetojoy;

  logic       clk;
  logic       RESET;
  logic [7:0] sw;
  logic       FREQ;
  logic [7:0] Led;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] prev_led;

  typedef struct {
    int         at;
    bit         is_freq;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  // hand-computed half periods at 10 kHz, by switch index (sw[0]=C5 .. sw[7]=C4)
  int half_tb [8] = '{10, 10, 11, 13, 14, 15, 17, 19};
  int mel [15] = '{5, 5, 4, 3, 3, 4, 5, 6, 7, 7, 6, 5, 5, 6, 6};
  logic [7:0] led_mel [15] = '{8'h20, 8'h10, 8'h08, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h80, 8'h40, 8'h20, 8'h20, 8'h40, 8'h40, 8'hFF};

  odetojoy #(.CLK_HZ(10_000)) dut (
    .CLK   (clk),
    .RESET (RESET),
    .sw    (sw),
    .FREQ  (FREQ),
    .Led   (Led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int at, input bit f, input logic [7:0] v, input string nm);
    exp_t e;
    e.at = at; e.is_freq = f; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  // 25 cycles held, 25 released; checks hint latency, tone phase and silence.
  task automatic press(input int b, input logic [7:0] led_after, input string nm);
    int n;
    n = cyc;
    sw = 8'(1 << b);
    chk(n + 2, 1'b0, prev_led, {nm, "_pre"});
    chk(n + 3, 1'b0, led_after, nm);
    chk(n + 1 + half_tb[b], 1'b1, 8'd0, {nm, "_lo"});
    chk(n + 2 + half_tb[b], 1'b1, 8'd1, {nm, "_hi"});
    prev_led = led_after;
    wait_to(n + 25);
    sw = '0;
    chk(n + 28, 1'b1, 8'd0, {nm, "_off"});
    wait_to(n + 50);
  endtask

  initial begin
    logic [7:0] act;
    forever begin
      @(negedge clk);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].at == cyc) begin
          act = exp_q[i].is_freq ? {7'b0, FREQ} : Led;
          n_tests++;
          if (act !== exp_q[i].val) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", exp_q[i].name, cyc, act, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    RESET = 1'b0;
    sw = '0;
    prev_led = 8'h20;
    @(negedge clk);

    // 1: reset values and quiet idle
    chk(3, 1'b0, 8'h20, "rst_led");
    chk(3, 1'b1, 8'd0, "rst_freq");
    wait_to(5);
    RESET = 1'b1;
    chk(6, 1'b0, 8'h20, "idle_led_a");
    chk(20, 1'b1, 8'd0, "idle_freq");
    chk(40, 1'b0, 8'h20, "idle_led_b");
    wait_to(45);

    // 2: hold E4, period 30
    n = cyc;
    sw = 8'h20;
    chk(n + 2, 1'b0, 8'h20, "e_pre");
    chk(n + 3, 1'b0, 8'h20, "e_led");
    chk(n + 16, 1'b1, 8'd0, "e_lo");
    chk(n + 17, 1'b1, 8'd1, "e_hi");
    chk(n + 31, 1'b1, 8'd1, "e_hi_end");
    chk(n + 32, 1'b1, 8'd0, "e_lo2");
    chk(n + 47, 1'b1, 8'd1, "e_hi2");
    wait_to(n + 50);
    sw = '0;
    chk(n + 52, 1'b1, 8'd1, "e_rel_hold");
    chk(n + 53, 1'b1, 8'd0, "e_rel_off");
    wait_to(n + 70);

    RESET = 1'b0;
    chk(cyc + 2, 1'b0, 8'h20, "rst2_led");
    wait_to(cyc + 3);
    RESET = 1'b1;
    prev_led = 8'h20;
    wait_to(cyc + 10);

    // 3: full melody
    for (int k = 0; k < 15; k++) press(mel[k], led_mel[k], $sformatf("mel%0d", k));

    // 4: restart after done, wrong keys
    press(5, 8'h20, "re_e1");
    press(5, 8'h10, "re_e2");
    press(2, 8'h20, "wrong_a");
    press(5, 8'h20, "re_e3");
    press(5, 8'h10, "re_e4");
    press(5, 8'h20, "wrong_e");

    // 5: two keys, C5 wins
    n = cyc;
    sw = 8'h81;
    chk(n + 2, 1'b0, 8'h20, "c5_pre");
    chk(n + 3, 1'b0, 8'h20, "c5_led");
    chk(n + 11, 1'b1, 8'd0, "c5_lo");
    chk(n + 12, 1'b1, 8'd1, "c5_hi");
    chk(n + 21, 1'b1, 8'd1, "c5_hi_end");
    chk(n + 22, 1'b1, 8'd0, "c5_lo2");
    chk(n + 32, 1'b1, 8'd1, "c5_hi2");
    wait_to(n + 35);
    sw = '0;
    chk(n + 37, 1'b1, 8'd1, "c5_rel_hold");
    chk(n + 38, 1'b1, 8'd0, "c5_rel_off");
    wait_to(n + 60);
    prev_led = 8'h20;

    // extra key while held is not a press; tone switches to F4
    press(5, 8'h20, "e_again");
    n = cyc;
    sw = 8'h20;
    chk(n + 2, 1'b0, 8'h20, "hold_pre");
    chk(n + 3, 1'b0, 8'h10, "hold_e");
    wait_to(n + 5);
    sw = 8'h30;
    chk(n + 20, 1'b0, 8'h10, "extra_key");
    chk(n + 20, 1'b1, 8'd0, "chg_lo");
    chk(n + 23, 1'b1, 8'd1, "chg_hi");
    wait_to(n + 30);
    sw = '0;
    chk(n + 32, 1'b1, 8'd1, "chg_rel_hold");
    chk(n + 33, 1'b1, 8'd0, "chg_rel_off");
    chk(n + 45, 1'b0, 8'h10, "extra_after");
    wait_to(n + 50);
    prev_led = 8'h10;

    // 6: reset mid-melody with a key held
    n = cyc;
    sw = 8'h10;
    chk(n + 2, 1'b0, 8'h10, "f_pre");
    chk(n + 3, 1'b0, 8'h08, "f_led");
    chk(n + 16, 1'b1, 8'd1, "f_hi");
    wait_to(n + 20);
    sw = 8'h20;
    RESET = 1'b0;
    chk(n + 21, 1'b1, 8'd0, "midrst_freq");
    chk(n + 21, 1'b0, 8'h20, "midrst_led");
    wait_to(n + 23);
    RESET = 1'b1;
    chk(n + 50, 1'b0, 8'h20, "held_thru_rst");
    wait_to(n + 60);
    sw = '0;
    wait_to(n + 80);
    prev_led = 8'h20;
    press(5, 8'h20, "post_e1");
    press(5, 8'h10, "post_e2");

    wait_to(cyc + 5);
    if (exp_q.size() != 0) begin
      foreach (exp_q[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: never checked (due %0d, now %0d)", exp_q[i].name, exp_q[i].at, cyc);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
